// File: rtl/cic_interp.sv
// CIC interpolator: comb cascade at the input rate, zero-stuffed integrator cascade
// at the output rate, with valid/ready handshakes on both sides.
module cic_interp #(
   parameter int WIDTH  = 16,
   parameter int RATE   = 8,
   parameter int STAGES = 3
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic signed [WIDTH-1:0] i_in_data,
   input  logic                    i_in_valid,
   output logic                    o_in_ready,
   output logic signed [WIDTH-1:0] o_out_data,
   output logic                    o_out_valid,
   input  logic                    i_out_ready
);

   localparam int LOG2R = $clog2(RATE);
   localparam int ACC_W = WIDTH + STAGES * LOG2R;
   localparam int SH    = (STAGES - 1) * LOG2R;
   localparam int CNT_W = LOG2R + 1;

   logic signed [ACC_W-1:0] combDly_q [STAGES];
   logic signed [ACC_W-1:0] integ_q   [STAGES];
   logic signed [ACC_W-1:0] hold_q;
   logic        [CNT_W-1:0] cnt_q;
   logic signed [WIDTH-1:0] outData_q;
   logic                    outValid_q;

   logic signed [ACC_W-1:0] combVal   [STAGES+1];
   logic signed [ACC_W-1:0] integ_d   [STAGES];
   logic signed [ACC_W-1:0] upVal;
   logic                    stepEn;
   logic                    inXfer;

   // Comb cascade runs on the live input; integrators chain through their own next values.
   always_comb begin
      combVal[0] = {{(ACC_W-WIDTH){i_in_data[WIDTH-1]}}, i_in_data};
      for (int s = 1; s <= STAGES; s++) begin
         combVal[s] = combVal[s-1] - combDly_q[s-1];
      end
      stepEn = (cnt_q != '0) && (!outValid_q || i_out_ready);
      upVal  = (cnt_q == CNT_W'(RATE)) ? hold_q : '0;
      integ_d[0] = integ_q[0] + upVal;
      for (int s = 1; s < STAGES; s++) begin
         integ_d[s] = integ_q[s] + integ_d[s-1];
      end
      o_in_ready = !i_reset && ((cnt_q == '0) || ((cnt_q == CNT_W'(1)) && stepEn));
      inXfer     = i_in_valid && o_in_ready;
   end

   // A new input reloads the phase counter in the same cycle the last step retires.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         for (int s = 0; s < STAGES; s++) begin
            combDly_q[s] <= '0;
            integ_q[s]   <= '0;
         end
         hold_q     <= '0;
         cnt_q      <= '0;
         outData_q  <= '0;
         outValid_q <= 1'b0;
      end else begin
         if (inXfer) begin
            for (int s = 0; s < STAGES; s++) begin
               combDly_q[s] <= combVal[s];
            end
            hold_q <= combVal[STAGES];
            cnt_q  <= CNT_W'(RATE);
         end else if (stepEn) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
         if (stepEn) begin
            for (int s = 0; s < STAGES; s++) begin
               integ_q[s] <= integ_d[s];
            end
            outData_q  <= integ_d[STAGES-1][SH+WIDTH-1:SH];
            outValid_q <= 1'b1;
         end else if (outValid_q && i_out_ready) begin
            outValid_q <= 1'b0;
         end
      end
   end

   assign o_out_data  = outData_q;
   assign o_out_valid = outValid_q;

endmodule

// File: tb/tb_cic_interp.sv
// Directed bench for cic_interp at RATE=4, STAGES=3, WIDTH=16 with hand-computed outputs.
module tb_cic_interp;

   localparam int WIDTH  = 16;
   localparam int RATE   = 4;
   localparam int STAGES = 3;

   logic                    clk = 1'b0;
   logic                    reset;
   logic signed [WIDTH-1:0] inData;
   logic                    inValid;
   logic                    inReady;
   logic signed [WIDTH-1:0] outData;
   logic                    outValid;
   logic                    outReady;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   int inVec[32];
   int nIn;
   int outVec[64];
   int nGot;
   int acceptWin[32];
   int nAcc;
   int firstValidWin;

   int impExp[16]   = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1, 0, 0, 0, 0, 0, 0};
   int constExp[7]  = '{62, 187, 375, 625, 812, 937, 1000};

   cic_interp #(.WIDTH(WIDTH), .RATE(RATE), .STAGES(STAGES)) dut (
      .i_clock     (clk),
      .i_reset     (reset),
      .i_in_data   (inData),
      .i_in_valid  (inValid),
      .o_in_ready  (inReady),
      .o_out_data  (outData),
      .o_out_valid (outValid),
      .i_out_ready (outReady)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected) passes++;
      else begin
         fails++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic applyReset();
      reset    = 1'b1;
      inValid  = 1'b0;
      inData   = '0;
      outReady = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Each window: drive inputs, let logic settle, sample, then cross one rising edge.
   task automatic applyStimulus(input int wantOut, input bit randReady, input int budget);
      int win = 0;
      int k = 0;
      bit pendHold = 1'b0;
      int heldVal = 0;
      nGot = 0;
      nAcc = 0;
      firstValidWin = -1;
      while (nGot < wantOut && win < budget) begin
         inValid = (k < nIn);
         if (k < nIn) inData = 16'(inVec[k]);
         else         inData = '0;
         outReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (pendHold) begin
            checkOutput("hold_valid", int'(outValid), 1);
            checkOutput("hold_data", int'(outData), heldVal);
         end
         pendHold = outValid && !outReady;
         heldVal  = int'(outData);
         if (outValid && firstValidWin < 0) firstValidWin = win;
         if (inValid && inReady) begin
            acceptWin[nAcc] = win;
            nAcc++;
            k++;
         end
         if (outValid && outReady) begin
            outVec[nGot] = int'(outData);
            nGot++;
         end
         @(posedge clk);
         #1;
         win++;
      end
      inValid  = 1'b0;
      outReady = 1'b1;
      checkOutput("burst_done", nGot, wantOut);
   endtask

   initial begin
      int xfers;
      int readyLow;

      reset    = 1'b1;
      inValid  = 1'b0;
      inData   = '0;
      outReady = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_valid", int'(outValid), 0);
      checkOutput("rst_ready", int'(inReady), 0);
      checkOutput("rst_data", int'(outData), 0);
      reset = 1'b0;

      xfers = 0;
      readyLow = 0;
      for (int i = 0; i < 200; i++) begin
         #1;
         if (outValid && outReady) xfers++;
         if (!inReady) readyLow++;
         @(posedge clk);
         #1;
      end
      checkOutput("idle_xfers", xfers, 0);
      checkOutput("idle_ready_low", readyLow, 0);

      applyReset();
      nIn = 4;
      inVec[0] = 16; inVec[1] = 0; inVec[2] = 0; inVec[3] = 0;
      applyStimulus(16, 1'b0, 100);
      for (int i = 0; i < 16; i++) checkOutput($sformatf("imp16[%0d]", i), outVec[i], impExp[i]);
      checkOutput("imp16_latency", firstValidWin - acceptWin[0], 2);

      applyReset();
      inVec[0] = -16;
      applyStimulus(16, 1'b0, 100);
      for (int i = 0; i < 16; i++) checkOutput($sformatf("impn16[%0d]", i), outVec[i], -impExp[i]);

      applyReset();
      nIn = 10;
      for (int i = 0; i < 10; i++) inVec[i] = 1000;
      applyStimulus(24, 1'b0, 200);
      for (int i = 0; i < 5; i++) checkOutput($sformatf("const_ready_gap[%0d]", i), acceptWin[i+1] - acceptWin[i], RATE);
      for (int i = 0; i < 7; i++) checkOutput($sformatf("const_ramp[%0d]", i), outVec[i], constExp[i]);
      for (int i = 9; i < 24; i++) checkOutput($sformatf("const_settle[%0d]", i), outVec[i], 1000);

      applyReset();
      nIn = 4;
      inVec[0] = 16; inVec[1] = 0; inVec[2] = 0; inVec[3] = 0;
      applyStimulus(16, 1'b1, 400);
      for (int i = 0; i < 16; i++) checkOutput($sformatf("bp_imp[%0d]", i), outVec[i], impExp[i]);

      applyReset();
      applyStimulus(2, 1'b0, 50);
      checkOutput("midrst_out0", outVec[0], 1);
      checkOutput("midrst_out1", outVec[1], 3);
      reset = 1'b1;
      inValid = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         checkOutput("midrst_valid", int'(outValid), 0);
         checkOutput("midrst_ready", int'(inReady), 0);
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      #1;
      checkOutput("release_ready", int'(inReady), 1);
      checkOutput("release_valid", int'(outValid), 0);
      applyStimulus(16, 1'b0, 100);
      for (int i = 0; i < 16; i++) checkOutput($sformatf("post_rst_imp[%0d]", i), outVec[i], impExp[i]);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
